// File: rtl/axis_measure_poller.sv
`timescale 1ns/1ps
// axis_measure_poller
//
// AXI4-Lite initiator that drives the control slave of axis_measure_top from
// fabric logic. It turns clear/start request pulses into single control-register
// writes. It also polls the 64-bit cycle counter and the last-frame register at a
// fixed interval and presents each complete poll as a one-cycle snapshot strobe.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   cmd_clear, cmd_start      one-cycle request pulses for control writes
//   poll_en                   level, enables the periodic poll timer
//   m_axi_aw*/w*/b*           AXI4-Lite write channels (master side)
//   m_axi_ar*/r*              AXI4-Lite read channels (master side)
//   snap_valid                one-cycle strobe, snap_* updated on the same cycle
//   snap_cycles               {cycles_hi, cycles_lo} from the last poll
//   snap_last_frame           last-frame register from the last poll
//   busy                      FSM not in IDLE
//   resp_err                  sticky flag for any non-OKAY BRESP/RRESP
//
// FSM states:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | arbitrate pending requests (clear > start > poll)
//   WRITE   | AW and W outstanding, each dropped on its own ready
//   WRESP   | waiting for the write response
//   RADDR   | read address outstanding for the current read index
//   RDATA   | waiting for read data, captured into the shadow registers
//   DONE    | publish shadow registers to snap_* and strobe snap_valid

module axis_measure_poller #(
    parameter logic [31:0] CONTROL_OFFSET    = 32'h00,
    parameter logic [31:0] CYCLES_OFFSET     = 32'h10,
    parameter logic [31:0] LAST_FRAME_OFFSET = 32'h18,
    parameter logic [31:0] SIG_CLEAR         = 32'h2,
    parameter logic [31:0] SIG_START         = 32'h1,
    parameter int unsigned POLL_INTERVAL     = 1000
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,

    input  logic        cmd_clear,
    input  logic        cmd_start,
    input  logic        poll_en,

    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic        snap_valid,
    output logic [63:0] snap_cycles,
    output logic [31:0] snap_last_frame,
    output logic        busy,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);

    state_t      state_q, state_d;

    logic        pend_clear_q, pend_clear_d;
    logic        pend_start_q, pend_start_d;
    logic        pend_poll_q,  pend_poll_d;

    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic        poll_tick;

    logic [1:0]  rd_idx_q, rd_idx_d;

    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;

    logic [31:0] sh_lo_q, sh_lo_d;
    logic [31:0] sh_hi_q, sh_hi_d;
    logic [31:0] sh_frame_q, sh_frame_d;

    logic [63:0] snap_cycles_q, snap_cycles_d;
    logic [31:0] snap_frame_q, snap_frame_d;
    logic        snap_valid_q, snap_valid_d;
    logic        resp_err_q, resp_err_d;

    // Read index -> register address: cycles low, cycles high, last frame.
    function automatic logic [31:0] rd_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    rd_addr = CYCLES_OFFSET;
            2'd1:    rd_addr = CYCLES_OFFSET + 32'd4;
            default: rd_addr = LAST_FRAME_OFFSET;
        endcase
    endfunction

    // Poll timer: free-runs while enabled, ticks on its last count and wraps.
    always_comb begin
        poll_tick  = 1'b0;
        poll_cnt_d = poll_cnt_q;
        if (!poll_en) begin
            poll_cnt_d = '0;
        end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d = '0;
            poll_tick  = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_clear_d  = pend_clear_q | cmd_clear;
        pend_start_d  = pend_start_q | cmd_start;
        pend_poll_d   = pend_poll_q;
        rd_idx_d      = rd_idx_q;
        awaddr_d      = awaddr_q;
        awvalid_d     = awvalid_q;
        wdata_d       = wdata_q;
        wvalid_d      = wvalid_q;
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        sh_lo_d       = sh_lo_q;
        sh_hi_d       = sh_hi_q;
        sh_frame_d    = sh_frame_q;
        snap_cycles_d = snap_cycles_q;
        snap_frame_d  = snap_frame_q;
        snap_valid_d  = 1'b0;
        resp_err_d    = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (pend_clear_q) begin
                    pend_clear_d = 1'b0;
                    awaddr_d     = CONTROL_OFFSET;
                    wdata_d      = SIG_CLEAR;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    state_d      = S_WRITE;
                end else if (pend_start_q) begin
                    pend_start_d = 1'b0;
                    awaddr_d     = CONTROL_OFFSET;
                    wdata_d      = SIG_START;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    state_d      = S_WRITE;
                end else if (pend_poll_q) begin
                    pend_poll_d  = 1'b0;
                    rd_idx_d     = 2'd0;
                    araddr_d     = rd_addr(2'd0);
                    arvalid_d    = 1'b1;
                    state_d      = S_RADDR;
                end
            end

            S_WRITE: begin
                // AW and W complete independently; leave once neither is pending.
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q  & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_WRESP;
                end
            end

            S_WRESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        resp_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end

            S_RADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end

            S_RDATA: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        resp_err_d = 1'b1;
                    end
                    case (rd_idx_q)
                        2'd0:    sh_lo_d    = m_axi_rdata;
                        2'd1:    sh_hi_d    = m_axi_rdata;
                        default: sh_frame_d = m_axi_rdata;
                    endcase
                    if (rd_idx_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        rd_idx_d  = rd_idx_q + 2'd1;
                        araddr_d  = rd_addr(rd_idx_q + 2'd1);
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end

            S_DONE: begin
                // Published even after an error response; resp_err marks it.
                snap_cycles_d = {sh_hi_q, sh_lo_q};
                snap_frame_d  = sh_frame_q;
                snap_valid_d  = 1'b1;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh tick wins over the acceptance clear above; disabling drops
        // any not-yet-accepted poll but never aborts one already running.
        if (poll_tick) begin
            pend_poll_d = 1'b1;
        end
        if (!poll_en) begin
            pend_poll_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            pend_clear_q  <= 1'b0;
            pend_start_q  <= 1'b0;
            pend_poll_q   <= 1'b0;
            poll_cnt_q    <= '0;
            rd_idx_q      <= '0;
            awaddr_q      <= '0;
            awvalid_q     <= 1'b0;
            wdata_q       <= '0;
            wvalid_q      <= 1'b0;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            sh_lo_q       <= '0;
            sh_hi_q       <= '0;
            sh_frame_q    <= '0;
            snap_cycles_q <= '0;
            snap_frame_q  <= '0;
            snap_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_clear_q  <= pend_clear_d;
            pend_start_q  <= pend_start_d;
            pend_poll_q   <= pend_poll_d;
            poll_cnt_q    <= poll_cnt_d;
            rd_idx_q      <= rd_idx_d;
            awaddr_q      <= awaddr_d;
            awvalid_q     <= awvalid_d;
            wdata_q       <= wdata_d;
            wvalid_q      <= wvalid_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            sh_lo_q       <= sh_lo_d;
            sh_hi_q       <= sh_hi_d;
            sh_frame_q    <= sh_frame_d;
            snap_cycles_q <= snap_cycles_d;
            snap_frame_q  <= snap_frame_d;
            snap_valid_q  <= snap_valid_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign m_axi_awaddr    = awaddr_q;
    assign m_axi_awvalid   = awvalid_q;
    assign m_axi_wdata     = wdata_q;
    assign m_axi_wstrb     = 4'hF;
    assign m_axi_wvalid    = wvalid_q;
    assign m_axi_bready    = (state_q == S_WRESP);
    assign m_axi_araddr    = araddr_q;
    assign m_axi_arvalid   = arvalid_q;
    assign m_axi_rready    = (state_q == S_RDATA);
    assign snap_valid      = snap_valid_q;
    assign snap_cycles     = snap_cycles_q;
    assign snap_last_frame = snap_frame_q;
    assign busy            = (state_q != S_IDLE);
    assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_axis_measure_poller.sv
`timescale 1ns/1ps
module tb_axis_measure_poller;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        cmd_start = 1'b0;
    logic        poll_en = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        snap_valid;
    logic [63:0] snap_cycles;
    logic [31:0] snap_last_frame;
    logic        busy;
    logic        resp_err;

    axis_measure_poller #(.POLL_INTERVAL(20)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_clear(cmd_clear), .cmd_start(cmd_start), .poll_en(poll_en),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .snap_valid(snap_valid), .snap_cycles(snap_cycles), .snap_last_frame(snap_last_frame),
        .busy(busy), .resp_err(resp_err)
    );

    always #5 ap_clk = ~ap_clk;

    int unsigned cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] cycles;
        logic [31:0] frame;
    } snap_t;

    logic [63:0] exp_wr[$];
    snap_t       exp_snap[$];
    int unsigned snap_stamp[$];
    logic [31:0] ar_log[$];

    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          b_count = 0;
    logic [31:0] rd_lo = 0, rd_hi = 0, rd_frame = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // Slave model and output monitor, evaluated on the falling edge.
    initial begin : slave
        logic        prev_awv, prev_wv, prev_bready, prev_arv, prev_rready;
        logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
        logic        got_aw, got_w, ar_got;
        logic [31:0] hs_awaddr, hs_wdata, ar_addr_got;
        logic [63:0] ew;
        snap_t       es;
        prev_awv = 0; prev_wv = 0; prev_bready = 0; prev_arv = 0; prev_rready = 0;
        prev_awaddr = 0; prev_wdata = 0; prev_araddr = 0;
        got_aw = 0; got_w = 0; ar_got = 0;
        hs_awaddr = 0; hs_wdata = 0; ar_addr_got = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                got_aw = 0; got_w = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (prev_awv && m_axi_awready) begin got_aw = 1; hs_awaddr = prev_awaddr; end
                if (prev_wv && m_axi_wready) begin got_w = 1; hs_wdata = prev_wdata; end
                if (prev_bready && m_axi_bvalid) begin m_axi_bvalid = 0; b_count++; end
                if (got_aw && got_w && !m_axi_bvalid) begin
                    got_aw = 0; got_w = 0;
                    n_checks++;
                    if (exp_wr.size() == 0) begin
                        n_errors++;
                        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", hs_awaddr, hs_wdata);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({hs_awaddr, hs_wdata} !== ew) begin
                            n_errors++;
                            $display("FAIL write_txn: got addr=%h data=%h, required addr=%h data=%h",
                                     hs_awaddr, hs_wdata, ew[63:32], ew[31:0]);
                        end
                    end
                    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
                end
                if (prev_arv && m_axi_arready) begin
                    ar_got = 1; ar_addr_got = prev_araddr; ar_log.push_back(prev_araddr);
                end
                if (prev_rready && m_axi_rvalid) m_axi_rvalid = 0;
                if (ar_got && !m_axi_rvalid) begin
                    ar_got = 0;
                    m_axi_rvalid = 1;
                    case (ar_addr_got)
                        32'h10:  m_axi_rdata = rd_lo;
                        32'h14:  m_axi_rdata = rd_hi;
                        32'h18:  m_axi_rdata = rd_frame;
                        default: m_axi_rdata = 32'hBAD0_BAD0;
                    endcase
                    m_axi_rresp = (ar_addr_got == err_addr) ? 2'b10 : 2'b00;
                end
                if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin m_axi_awready = 0; aw_cnt = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
                else begin m_axi_wready = 0; w_cnt = 0; end
                if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_delay); ar_cnt++; end
                else begin m_axi_arready = 0; ar_cnt = 0; end
                if (snap_valid) begin
                    snap_stamp.push_back(cyc);
                    n_checks++;
                    if (exp_snap.size() == 0) begin
                        n_errors++;
                        $display("FAIL snap_unexpected: got cycles=%h frame=%h, required no snapshot",
                                 snap_cycles, snap_last_frame);
                    end else begin
                        es = exp_snap.pop_front();
                        if (snap_cycles !== es.cycles || snap_last_frame !== es.frame) begin
                            n_errors++;
                            $display("FAIL snap_data: got cycles=%h frame=%h, required cycles=%h frame=%h",
                                     snap_cycles, snap_last_frame, es.cycles, es.frame);
                        end
                    end
                end
            end
            prev_awv = m_axi_awvalid; prev_wv = m_axi_wvalid; prev_bready = m_axi_bready;
            prev_arv = m_axi_arvalid; prev_rready = m_axi_rready;
            prev_awaddr = m_axi_awaddr; prev_wdata = m_axi_wdata; prev_araddr = m_axi_araddr;
        end
    end

    task automatic pulse(input logic clr, input logic st);
        @(negedge ap_clk);
        cmd_clear = clr; cmd_start = st;
        @(negedge ap_clk);
        cmd_clear = 0; cmd_start = 0;
    endtask

    task automatic test_reset();
        int active;
        repeat (3) @(negedge ap_clk);
        n_checks++;
        if (m_axi_awvalid !== 0 || m_axi_wvalid !== 0 || m_axi_arvalid !== 0 ||
            m_axi_bready !== 0 || m_axi_rready !== 0) begin
            n_errors++;
            $display("FAIL reset_valids: got aw=%b w=%b ar=%b b=%b r=%b, required all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready);
        end
        ap_rst_n = 1;
        @(negedge ap_clk);
        n_checks++;
        if (m_axi_awaddr !== 0 || m_axi_wdata !== 0 || m_axi_araddr !== 0 || m_axi_wstrb !== 4'hF) begin
            n_errors++;
            $display("FAIL reset_addr_data: got awaddr=%h wdata=%h araddr=%h wstrb=%h, required 0 0 0 f",
                     m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_wstrb);
        end
        n_checks++;
        if (snap_valid !== 0 || snap_cycles !== 0 || snap_last_frame !== 0 || busy !== 0 || resp_err !== 0) begin
            n_errors++;
            $display("FAIL reset_status: got sv=%b cyc=%h fr=%h busy=%b err=%b, required all 0",
                     snap_valid, snap_cycles, snap_last_frame, busy, resp_err);
        end
        active = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || busy || snap_valid) active++;
        end
        n_checks++;
        if (active != 0) begin
            n_errors++;
            $display("FAIL idle_quiet: got %0d active cycles, required 0", active);
        end
    endtask

    task automatic test_clear();
        int b0, t;
        aw_delay = 0; w_delay = 1;
        b0 = b_count;
        exp_wr.push_back({32'h0, 32'h2});
        pulse(1, 0);
        n_checks++;
        if (m_axi_awvalid !== 0 || busy !== 0) begin
            n_errors++;
            $display("FAIL clear_early: got awvalid=%b busy=%b, required 0 0", m_axi_awvalid, busy);
        end
        @(negedge ap_clk);
        n_checks++;
        if (m_axi_awvalid !== 1 || m_axi_wvalid !== 1 || m_axi_awaddr !== 32'h0 ||
            m_axi_wdata !== 32'h2 || m_axi_wstrb !== 4'hF || busy !== 1) begin
            n_errors++;
            $display("FAIL clear_issue: got awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h busy=%b, required 1 1 0 2 f 1",
                     m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb, busy);
        end
        @(negedge ap_clk);
        n_checks++;
        if (m_axi_awvalid !== 0 || m_axi_wvalid !== 1 || m_axi_wdata !== 32'h2) begin
            n_errors++;
            $display("FAIL clear_w_held: got awv=%b wv=%b wdata=%h, required 0 1 2",
                     m_axi_awvalid, m_axi_wvalid, m_axi_wdata);
        end
        t = 0;
        while (busy && t < 50) begin @(negedge ap_clk); t++; end
        n_checks++;
        if (busy !== 0 || b_count - b0 != 1 || exp_wr.size() != 0) begin
            n_errors++;
            $display("FAIL clear_done: got busy=%b bresp_hs=%0d pending=%0d, required 0 1 0",
                     busy, b_count - b0, exp_wr.size());
        end
        w_delay = 0;
    endtask

    task automatic test_back_to_back();
        int b0, t;
        b0 = b_count;
        exp_wr.push_back({32'h0, 32'h2});
        exp_wr.push_back({32'h0, 32'h1});
        pulse(1, 1);
        t = 0;
        while ((exp_wr.size() != 0 || busy) && t < 60) begin @(negedge ap_clk); t++; end
        n_checks++;
        if (exp_wr.size() != 0 || busy !== 0 || b_count - b0 != 2) begin
            n_errors++;
            $display("FAIL b2b_done: got pending=%0d busy=%b bresp_hs=%0d, required 0 0 2",
                     exp_wr.size(), busy, b_count - b0);
        end
    endtask

    task automatic test_poll();
        int unsigned c0;
        int t;
        rd_lo = 32'h5; rd_hi = 32'h1; rd_frame = 32'h1E;
        for (int i = 0; i < 3; i++) exp_snap.push_back({64'h1_0000_0005, 32'd30});
        snap_stamp.delete(); ar_log.delete();
        @(negedge ap_clk);
        poll_en = 1; c0 = cyc;
        t = 0;
        while (snap_stamp.size() < 3 && t < 200) begin @(negedge ap_clk); t++; end
        poll_en = 0;
        n_checks++;
        if (snap_stamp.size() < 3) begin
            n_errors++;
            $display("FAIL poll_timeout: got %0d snapshots, required 3", snap_stamp.size());
        end else begin
            n_checks++;
            if (snap_stamp[0] - c0 != 28) begin
                n_errors++;
                $display("FAIL poll_first_latency: got %0d cycles, required 28", snap_stamp[0] - c0);
            end
            n_checks++;
            if (snap_stamp[1] - snap_stamp[0] != 20 || snap_stamp[2] - snap_stamp[1] != 20) begin
                n_errors++;
                $display("FAIL poll_interval: got %0d and %0d, required 20 and 20",
                         snap_stamp[1] - snap_stamp[0], snap_stamp[2] - snap_stamp[1]);
            end
            n_checks++;
            if (ar_log.size() < 3 || ar_log[0] !== 32'h10 || ar_log[1] !== 32'h14 || ar_log[2] !== 32'h18) begin
                n_errors++;
                $display("FAIL poll_addrs: got %0d reads first=%h, required 10 14 18",
                         ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hX);
            end
        end
        repeat (10) @(negedge ap_clk);
        n_checks++;
        if (busy !== 0 || resp_err !== 0 || exp_snap.size() != 0) begin
            n_errors++;
            $display("FAIL poll_end: got busy=%b err=%b pending=%0d, required 0 0 0",
                     busy, resp_err, exp_snap.size());
        end
    endtask

    task automatic test_resp_err();
        int t, n0;
        rd_lo = 32'hDEAD_BEEF; rd_hi = 32'h1234_5678; rd_frame = 32'h7;
        err_addr = 32'h14;
        exp_snap.push_back({64'h1234_5678_DEAD_BEEF, 32'h7});
        n0 = snap_stamp.size();
        @(negedge ap_clk);
        poll_en = 1;
        t = 0;
        while (snap_stamp.size() == n0 && t < 100) begin @(negedge ap_clk); t++; end
        poll_en = 0;
        err_addr = 32'hFFFF_FFFF;
        n_checks++;
        if (snap_stamp.size() == n0 || resp_err !== 1) begin
            n_errors++;
            $display("FAIL rresp_err: got snapshots=%0d err=%b, required %0d 1",
                     snap_stamp.size(), resp_err, n0 + 1);
        end
        exp_wr.push_back({32'h0, 32'h1});
        pulse(0, 1);
        t = 0;
        while ((exp_wr.size() != 0 || busy) && t < 50) begin @(negedge ap_clk); t++; end
        n_checks++;
        if (resp_err !== 1 || exp_wr.size() != 0) begin
            n_errors++;
            $display("FAIL err_sticky: got err=%b pending=%0d, required 1 0", resp_err, exp_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        int t, n0;
        ar_delay = 1000;
        ar_log.delete();
        @(negedge ap_clk);
        poll_en = 1;
        t = 0;
        while (!m_axi_arvalid && t < 100) begin @(negedge ap_clk); t++; end
        repeat (3) @(negedge ap_clk);
        n_checks++;
        if (m_axi_arvalid !== 1 || m_axi_araddr !== 32'h10) begin
            n_errors++;
            $display("FAIL ar_held: got arvalid=%b araddr=%h, required 1 10", m_axi_arvalid, m_axi_araddr);
        end
        #2;
        ap_rst_n = 0;
        poll_en = 0;
        #1;
        n_checks++;
        if (m_axi_arvalid !== 0 || busy !== 0 || resp_err !== 0 || snap_cycles !== 0) begin
            n_errors++;
            $display("FAIL async_reset: got arvalid=%b busy=%b err=%b cyc=%h, required 0 0 0 0",
                     m_axi_arvalid, busy, resp_err, snap_cycles);
        end
        repeat (3) @(negedge ap_clk);
        ar_delay = 0;
        ap_rst_n = 1;
        rd_lo = 32'h11; rd_hi = 32'h22; rd_frame = 32'h33;
        exp_snap.push_back({64'h0000_0022_0000_0011, 32'h33});
        n0 = snap_stamp.size();
        @(negedge ap_clk);
        poll_en = 1;
        t = 0;
        while (snap_stamp.size() == n0 && t < 100) begin @(negedge ap_clk); t++; end
        poll_en = 0;
        n_checks++;
        if (ar_log.size() != 3 || ar_log[0] !== 32'h10) begin
            n_errors++;
            $display("FAIL restart_index: got %0d reads first=%h, required 3 first=10",
                     ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : 32'hX);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_poll();
        test_resp_err();
        test_reset_mid();
        repeat (5) @(negedge ap_clk);
        n_checks++;
        if (exp_wr.size() != 0 || exp_snap.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got writes=%0d snaps=%0d left, required 0 0",
                     exp_wr.size(), exp_snap.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
